wrapper_digest_packetiser: RTL and testbench

Downstream of the digest valid filter. Captures the final DIGEST_W-bit hash on each single-cycle hash_valid_i pulse. Serialises it MSW-first onto an AXI-Stream master as one packet, with m_tlast_o on the final word. A 2-entry digest buffer absorbs back-to-back hashes while the stream is stalled. Overflow is flagged sticky.

---
 rtl/wrapper_digest_pkg.sv | 19 +
 rtl/wrapper_digest_buffer.sv | 52 +++++
 rtl/wrapper_digest_packetiser.sv | 141 ++++++++++++++
 tb/tb_wrapper_digest_packetiser.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wrapper_digest_pkg.sv
// wrapper_digest_pkg: shared constants, FSM state type and word-count helper
// for the digest packetiser. Optional header build: WRAPPER_DIGEST_PKT_HDR_EN.
package wrapper_digest_pkg;

  localparam int DIGEST_W_D = 256;
  localparam int DATA_W_D   = 64;
  localparam int SEQ_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  function automatic int words_f(input int dw, input int w);
    return dw / w;
  endfunction

endpackage

// File: rtl/wrapper_digest_buffer.sv
// wrapper_digest_buffer: 2-entry digest FIFO with 1-bit wrapping pointers.
// Ports: clk, rst (sync, high), i_push/i_data, i_pop, o_head, o_count,
// o_full, o_empty. Caller guarantees no push when full without a pop.
module wrapper_digest_buffer
  import wrapper_digest_pkg::*;
#(
  parameter int W = DIGEST_W_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  // Push-while-full only happens with a same-cycle pop, so the slot
  // written is the one just released by the head.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/wrapper_digest_packetiser.sv
// wrapper_digest_packetiser: buffers digests and streams them MSW-first as
// AXI-Stream packets. Ports: clk, rst (sync, high), hash_valid_i, digest_i,
// m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o, overflow_o (sticky), busy_o.
// WRAPPER_DIGEST_PKT_HDR_EN prepends a sequence-number header word.
module wrapper_digest_packetiser
  import wrapper_digest_pkg::*;
#(
  parameter int DIGEST_W = DIGEST_W_D,
  parameter int DATA_W   = DATA_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hash_valid_i,
  input  logic [DIGEST_W-1:0] digest_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int WORDS = words_f(DIGEST_W, DATA_W);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef WRAPPER_DIGEST_PKT_HDR_EN
  localparam state_e START = HDR;
`else
  localparam state_e START = DATA;
`endif

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_ovf;

  logic                 w_hs;
  logic                 w_last;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_more;
  logic [DIGEST_W-1:0]  w_head;
  logic [DIGEST_W-1:0]  w_shift;
  logic [1:0]           w_count;
  logic                 w_full;
  logic                 w_empty;

  assign m_tvalid_o = (r_state != IDLE);
  assign w_hs       = m_tvalid_o & m_tready_i;
  assign w_last     = (r_state == DATA) && (int'(r_idx) == WORDS - 1);
  assign w_pop      = w_hs & w_last;
  // A full buffer still accepts when its head leaves in the same cycle.
  assign w_push     = hash_valid_i & (~w_full | w_pop);
  // Something left to send after the pop: count - 1 + push > 0.
  assign w_more     = ({1'b0, w_count} + {2'b00, w_push}) > 3'd1;

  wrapper_digest_buffer #(
    .W (DIGEST_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (digest_i),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (!w_empty || w_push) begin
          w_state_nxt = START;
          w_idx_nxt   = '0;
        end
      end
      HDR: begin
        if (w_hs) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_hs) begin
          if (w_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = w_more ? START : IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                         r_ovf <= 1'b0;
    else if (hash_valid_i & ~w_push) r_ovf <= 1'b1;
  end

  // Word k of the head is its k-th most significant DATA_W slice.
  assign w_shift = w_head >> (DATA_W * (WORDS - 1 - int'(r_idx)));

`ifdef WRAPPER_DIGEST_PKT_HDR_EN
  logic [SEQ_W-1:0] r_seq;

  always_ff @(posedge clk) begin
    if (rst)        r_seq <= '0;
    else if (w_pop) r_seq <= r_seq + SEQ_W'(1);
  end

  always_comb begin
    m_tdata_o = '0;
    if (r_state == DATA)     m_tdata_o = w_shift[DATA_W-1:0];
    else if (r_state == HDR) m_tdata_o = DATA_W'(r_seq);
  end
`else
  always_comb begin
    m_tdata_o = '0;
    if (r_state == DATA) m_tdata_o = w_shift[DATA_W-1:0];
  end
`endif

  assign m_tlast_o  = w_last;
  assign overflow_o = r_ovf;
  assign busy_o     = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_wrapper_digest_packetiser.sv
// tb_wrapper_digest_packetiser: random and directed stimulus checked against
// a queue-based packet model of the digest packetiser.
module tb_wrapper_digest_packetiser;

  localparam int DW    = 256;
  localparam int W     = 64;
  localparam int WORDS = DW / W;
`ifdef WRAPPER_DIGEST_PKT_HDR_EN
  localparam int HDRW  = 1;
`else
  localparam int HDRW  = 0;
`endif
  localparam int L     = WORDS + HDRW;

  localparam logic [DW-1:0] DIG0 =
    256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          hash_valid_i;
  logic [DW-1:0] digest_i;
  logic [W-1:0]  m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tready_i;
  logic          m_tlast_o;
  logic          overflow_o;
  logic          busy_o;

  wrapper_digest_packetiser #(
    .DIGEST_W (DW),
    .DATA_W   (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hash_valid_i (hash_valid_i),
    .digest_i     (digest_i),
    .m_tdata_o    (m_tdata_o),
    .m_tvalid_o   (m_tvalid_o),
    .m_tready_i   (m_tready_i),
    .m_tlast_o    (m_tlast_o),
    .overflow_o   (overflow_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: queue of accepted digests, head is the packet in flight
  logic [DW-1:0] q [$];
  int            pos;
  bit            m_ovf;
  logic [31:0]   m_seq;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word();
    logic [DW-1:0] h;
    int k;
    h = q[0];
    if (pos < HDRW) return {32'd0, m_seq};
    k = pos - HDRW;
    return h[DW-1-k*W -: W];
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Check outputs mid-cycle, then advance the model across the next edge.
  task automatic step();
    bit ev;
    bit hs;
    bit fin;
    ev = (q.size() != 0);
    chk("tvalid", W'(m_tvalid_o), W'(ev));
    chk("busy", W'(busy_o), W'(ev));
    chk("overflow", W'(overflow_o), W'(m_ovf));
    chk("tlast", W'(m_tlast_o), W'(ev && pos == L - 1));
    if (ev) chk("tdata", m_tdata_o, exp_word());
    if (rst) begin
      q.delete();
      pos   = 0;
      m_ovf = 0;
      m_seq = '0;
    end else begin
      hs  = ev && m_tready_i;
      fin = hs && pos == L - 1;
      if (hash_valid_i && !(q.size() < 2 || fin)) m_ovf = 1;
      if (fin) begin
        void'(q.pop_front());
        pos = 0;
        m_seq++;
      end else if (hs) begin
        pos++;
      end
      if (hash_valid_i && (q.size() < 2 || fin))
        q.push_back(digest_i);
    end
  endtask

  task automatic cyc(input bit r, input bit hv,
                     input logic [DW-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    rst          = r;
    hash_valid_i = hv;
    digest_i     = d;
    m_tready_i   = rdy;
    @(negedge clk);
    step();
  endtask

  task automatic run_phase(input int n, input int hv_pct,
                           input int rdy_pct, input int rst_pct);
    bit r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(99) < rst_pct);
      cyc(r, !r && ($urandom_range(99) < hv_pct), rnd256(),
          $urandom_range(99) < rdy_pct);
    end
  endtask

  int ph [6][3] = '{
    '{40, 100, 0},
    '{50, 50, 0},
    '{70, 10, 0},
    '{20, 80, 2},
    '{90, 30, 1},
    '{10, 95, 0}
  };

  initial begin
    rst          = 1'b1;
    hash_valid_i = 1'b0;
    digest_i     = '0;
    m_tready_i   = 1'b0;
    q.delete();
    pos   = 0;
    m_ovf = 0;
    m_seq = '0;
    repeat (2) @(posedge clk);

    // single hash, always ready
    cyc(0, 1, DIG0, 1);
    repeat (L + 2) cyc(0, 0, '0, 1);
    // same hash with stalls
    cyc(0, 1, DIG0, 1);
    for (int i = 0; i < 3 * L; i++) cyc(0, 0, '0, (i % 3) == 0);
    // two hashes one cycle apart
    cyc(0, 1, DIG0, 1);
    cyc(0, 1, ~DIG0, 1);
    repeat (2 * L + 2) cyc(0, 0, '0, 1);
    // stalled: A,B buffered, C dropped, then drain
    cyc(0, 1, DIG0, 0);
    cyc(0, 1, ~DIG0, 0);
    cyc(0, 1, rnd256(), 0);
    repeat (3) cyc(0, 0, '0, 0);
    repeat (2 * L + 2) cyc(0, 0, '0, 1);
    // mid-packet reset
    cyc(1, 0, '0, 0);
    cyc(0, 1, DIG0, 1);
    cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 1);
    cyc(0, 1, ~DIG0, 1);
    repeat (L + 2) cyc(0, 0, '0, 1);

    foreach (ph[p]) begin
      cyc(1, 0, '0, 0);
      run_phase(400, ph[p][0], ph[p][1], ph[p][2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
